// File: rtl/sap_ram_pkg.sv
// rtl/sap_ram_pkg.sv - shared state encoding and default widths for the SAP-U RAM unit
package sap_ram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_PROG  = 2'd2
    } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - multi-flop synchroniser with rising-edge pulse for front-panel inputs
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign pulse = level & ~prev_q;

endmodule

// File: rtl/sap_ram_unit.sv
// rtl/sap_ram_unit.sv - SAP-U main memory, MAR and front-panel programming; SAP_RAM_CLEAR_EN adds a post-reset clear sweep
module sap_ram_unit
    import sap_ram_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              btn_addr,
    input  logic              btn_write,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_load,
    input  logic              ram_in,
    input  logic              ram_out,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] mar_q,
    output logic              prog_led,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] MAR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mar_d;
    logic                prog_lvl, prog_pulse_unused;
    logic                addr_pulse, write_pulse, addr_unused, write_unused;
    logic                addr_ok;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   mem [DEPTH];

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
        .clk(clk), .clr_n(clr_n), .din(prog_mode), .level(prog_lvl), .pulse(prog_pulse_unused)
    );
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_addr (
        .clk(clk), .clr_n(clr_n), .din(btn_addr), .level(addr_unused), .pulse(addr_pulse)
    );
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_write (
        .clk(clk), .clr_n(clr_n), .din(btn_write), .level(write_unused), .pulse(write_pulse)
    );

    // Locations at or above DEPTH are unimplemented: writes vanish, reads give zero.
    assign addr_ok = ({1'b0, mar_q} < DEPTH_EXT);
    assign rd_data = addr_ok ? mem[mar_q] : '0;

`ifdef SAP_RAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= S_CLEAR;
            mar_q     <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Gated by clr_n so busy reads 0 while reset is held, even though the state is already S_CLEAR.
    assign busy = (state_q == S_CLEAR) & clr_n;
`else
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_RUN;
            mar_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
        end
    end

    assign busy = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        mem_we    = 1'b0;
        mem_waddr = mar_q;
        mem_wdata = bus_in;
`ifdef SAP_RAM_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
`ifdef SAP_RAM_CLEAR_EN
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == MAR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = prog_lvl ? S_PROG : S_RUN;
                end
            end
`endif
            S_RUN: begin
                // The write uses the pre-edge MAR even if MAR is reloaded in the same cycle.
                mem_we = ram_in & addr_ok;
                if (mar_load) mar_d = bus_in[ADDR_W-1:0];
                if (prog_lvl) state_d = S_PROG;
            end
            S_PROG: begin
                if (!prog_lvl) begin
                    state_d = S_RUN;
                end else if (addr_pulse) begin
                    mar_d = sw_addr;
                end else if (write_pulse) begin
                    mem_we    = addr_ok;
                    mem_wdata = sw_data;
                    mar_d     = (mar_q == MAR_LAST) ? '0 : mar_q + 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus_oe   = (state_q == S_RUN) & ram_out;
    assign bus_out  = bus_oe ? rd_data : '0;
    assign prog_led = (state_q == S_PROG);

endmodule
